boruss_fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the boruss CPU control FSM.
- Owns the program counter and reads 16-bit instruction words from a synchronous program ROM.
- Fetches the optional immediate word and hands a complete instruction (word, immediate, address) to the FSM over a valid/ready handshake.
- Advances only on the slow-clock enable tick and supports PC redirect (jumps) and a HALT opcode.

---
 rtl/boruss_fetch_unit_if.sv | 27 ++
 rtl/boruss_fetch_unit.sv | 106 ++++++++++
 tb/tb_boruss_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/boruss_fetch_unit_if.sv
// Fetch-unit bus bundle: ROM read port, instruction handshake toward the control FSM, and PC redirect.
// An instruction transfers on a ce-qualified clk edge where instr_valid && instr_ready; once
// instr_valid is high, instr_word/instr_imm/instr_pc hold until that transfer or a redirect.
interface boruss_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd_en;
    logic [15:0]           mem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [15:0]           instr_word;
    logic [7:0]            instr_imm;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_addr;

    modport master (
        output mem_addr, mem_rd_en, instr_valid, instr_word, instr_imm, instr_pc,
        input  mem_rdata, instr_ready, redirect_valid, redirect_addr
    );

    modport slave (
        input  mem_addr, mem_rd_en, instr_valid, instr_word, instr_imm, instr_pc,
        output mem_rdata, instr_ready, redirect_valid, redirect_addr
    );
endinterface

// File: rtl/boruss_fetch_unit.sv
// boruss instruction fetch stage: PC, two-beat ROM fetch (opcode + optional immediate), HALT and redirect.
// Define BORUSS_FETCH_STATS_EN to add the saturating fetch_count output.
module boruss_fetch_unit #(
    parameter int unsigned                ADDR_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]      RESET_PC    = '0,
    parameter logic [3:0]                 HALT_OPCODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    boruss_fetch_unit_if.master   bus,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic [2:0]            state
`ifdef BORUSS_FETCH_STATS_EN
    ,
    output logic [15:0]           fetch_count
`endif
);

    typedef enum logic [2:0] {
        ISSUE_OP  = 3'd0,
        CAPT_OP   = 3'd1,
        ISSUE_IMM = 3'd2,
        CAPT_IMM  = 3'd3,
        VALID     = 3'd4,
        HALTED    = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic                  cap_op, cap_imm;

    // pc only moves at capture, so the ROM address is stable across any ce spacing.
    assign bus.mem_addr    = pc;
    assign bus.mem_rd_en   = (state_q == ISSUE_OP) || (state_q == CAPT_OP) ||
                             (state_q == ISSUE_IMM) || (state_q == CAPT_IMM);
    assign bus.instr_valid = (state_q == VALID);
    assign halted          = (state_q == HALTED);
    assign state           = state_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        cap_op  = 1'b0;
        cap_imm = 1'b0;
        case (state_q)
            ISSUE_OP:  state_d = CAPT_OP;
            CAPT_OP: begin
                cap_op  = 1'b1;
                pc_d    = pc + ADDR_WIDTH'(1);
                state_d = bus.mem_rdata[3] ? ISSUE_IMM : VALID;
            end
            ISSUE_IMM: state_d = CAPT_IMM;
            CAPT_IMM: begin
                cap_imm = 1'b1;
                pc_d    = pc + ADDR_WIDTH'(1);
                state_d = VALID;
            end
            VALID: begin
                if (bus.instr_ready)
                    state_d = (bus.instr_word[15:12] == HALT_OPCODE) ? HALTED : ISSUE_OP;
            end
            HALTED:    state_d = HALTED;
            default:   state_d = ISSUE_OP;
        endcase
        // A redirect drops any half-fetched instruction; an accept in the same tick still counts.
        if (bus.redirect_valid) begin
            state_d = ISSUE_OP;
            pc_d    = bus.redirect_addr;
            cap_op  = 1'b0;
            cap_imm = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ISSUE_OP;
            pc             <= RESET_PC;
            bus.instr_word <= '0;
            bus.instr_imm  <= '0;
            bus.instr_pc   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            pc      <= pc_d;
            if (cap_op) begin
                bus.instr_word <= bus.mem_rdata;
                bus.instr_pc   <= pc;
                if (!bus.mem_rdata[3])
                    bus.instr_imm <= '0;
            end
            if (cap_imm)
                bus.instr_imm <= bus.mem_rdata[7:0];
        end
    end

`ifdef BORUSS_FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset)
            fetch_count <= '0;
        else if (ce && bus.instr_valid && bus.instr_ready && (fetch_count != 16'hFFFF))
            fetch_count <= fetch_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_boruss_fetch_unit.sv
// Self-checking bench for boruss_fetch_unit: table of single-instruction fetches plus hand-written
// sequences for reset, back-pressure, HALT/redirect, slow ce and reset during an immediate fetch.
module tb_boruss_fetch_unit;

    logic       clk;
    logic       reset;
    logic       ce;
    logic [7:0] pc;
    logic       halted;
    logic [2:0] state;
`ifdef BORUSS_FETCH_STATS_EN
    logic [15:0] fetch_count;
`endif

    boruss_fetch_unit_if #(.ADDR_WIDTH(8)) bus ();

    boruss_fetch_unit #(
        .ADDR_WIDTH (8),
        .RESET_PC   (8'h00),
        .HALT_OPCODE(4'hF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .bus        (bus.master),
        .pc         (pc),
        .halted     (halted),
        .state      (state)
`ifdef BORUSS_FETCH_STATS_EN
        ,
        .fetch_count(fetch_count)
`endif
    );

    // ---------------- clock / reset / ROM model ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] rom [0:255];
    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rdata <= rom[bus.mem_addr];
    end

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_accept = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [15:0] w, input logic [7:0] imm, input logic [7:0] ipc);
        return {w, imm, ipc};
    endfunction

    function automatic logic [63:0] snapshot();
        return {11'd0, bus.mem_addr, bus.mem_rd_en, bus.instr_valid, bus.instr_word,
                bus.instr_imm, bus.instr_pc, pc, state};
    endfunction

    always @(negedge clk) begin
        if (!reset && ce && bus.instr_valid && bus.instr_ready) begin
            n_accept++;
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", {32'd0, pack(bus.instr_word, bus.instr_imm, bus.instr_pc)}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("handshake", {32'd0, pack(bus.instr_word, bus.instr_imm, bus.instr_pc)}, {32'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!bus.instr_valid && n < limit);
        if (!bus.instr_valid)
            check("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic redirect(input logic [7:0] addr);
        bus.redirect_addr  = addr;
        bus.redirect_valid = 1'b1;
        step(1);
        bus.redirect_valid = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] op;
        logic [15:0] imm_word;
        logic [7:0]  exp_imm;
        int          exp_lat;
        logic [7:0]  exp_next_pc;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   lat;
        logic [63:0] snap;
        logic stable;

        vecs[0] = '{addr: 8'h00, op: 16'h0008, imm_word: 16'h0001, exp_imm: 8'h01, exp_lat: 4, exp_next_pc: 8'h02};
        vecs[1] = '{addr: 8'h20, op: 16'h1230, imm_word: 16'h0000, exp_imm: 8'h00, exp_lat: 2, exp_next_pc: 8'h21};
        vecs[2] = '{addr: 8'h40, op: 16'h5A7B, imm_word: 16'h12C4, exp_imm: 8'hC4, exp_lat: 4, exp_next_pc: 8'h42};
        vecs[3] = '{addr: 8'hFE, op: 16'h3457, imm_word: 16'h9999, exp_imm: 8'h00, exp_lat: 2, exp_next_pc: 8'hFF};
        vecs[4] = '{addr: 8'h80, op: 16'h2FFF, imm_word: 16'h00AB, exp_imm: 8'hAB, exp_lat: 4, exp_next_pc: 8'h82};
        vecs[5] = '{addr: 8'hFF, op: 16'h1008, imm_word: 16'h0042, exp_imm: 8'h42, exp_lat: 4, exp_next_pc: 8'h01};

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'h0008;
        rom[8'h01] = 16'h0001;
        rom[8'h02] = 16'h1230;
        rom[8'h03] = 16'hF000;
        rom[8'h10] = 16'h4560;

        reset = 1'b1;
        ce = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr = 8'h00;
        step(3);

        // Reset state
        check("reset_valid",  {63'd0, bus.instr_valid}, 64'd0);
        check("reset_regs",   {24'd0, bus.instr_word, bus.instr_imm, bus.instr_pc}, 64'd0);
        check("reset_pc",     {56'd0, pc}, 64'h00);
        check("reset_halted", {63'd0, halted}, 64'd0);
        check("reset_state",  {61'd0, state}, 64'd0);

        // Test 1: immediate instruction right after reset
        exp_q.push_back(pack(16'h0008, 8'h01, 8'h00));
        reset = 1'b0;
        n_accept = 0;
        wait_valid(20, lat);
        check("t1_latency", lat, 4);
        step(1);
        bus.instr_ready = 1'b0;
        check("t1_pc_after", {56'd0, pc}, 64'h02);

        // Test 2: back-pressure holds the plain instruction at 02
        wait_valid(20, lat);
        check("t2_latency", lat, 2);
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (!bus.instr_valid || bus.instr_word !== 16'h1230 || bus.instr_imm !== 8'h00 || bus.instr_pc !== 8'h02)
                stable = 1'b0;
            step(1);
        end
        check("t2_hold_stable", {63'd0, stable}, 64'd1);
        exp_q.push_back(pack(16'h1230, 8'h00, 8'h02));
        exp_q.push_back(pack(16'hF000, 8'h00, 8'h03));
        bus.instr_ready = 1'b1;
        step(1);
        check("t2_pc_after", {56'd0, pc}, 64'h03);
        check("t2_rd_en_after", {63'd0, bus.mem_rd_en}, 64'd1);

        // Test 3: HALT then redirect to 10
        lat = 0;
        while (!halted && lat < 20) begin
            step(1);
            lat++;
        end
        check("t3_halted", {63'd0, halted}, 64'd1);
        check("t3_rd_en", {63'd0, bus.mem_rd_en}, 64'd0);
        step(5);
        check("t3_pc_holds", {56'd0, pc}, 64'h04);
        check("t3_still_halted", {63'd0, halted}, 64'd1);
        redirect(8'h10);
        check("t3_unhalted", {63'd0, halted}, 64'd0);
        check("t3_redirect_pc", {56'd0, pc}, 64'h10);
        exp_q.push_back(pack(16'h4560, 8'h00, 8'h10));
        wait_valid(20, lat);
        check("t3_latency", lat, 2);
        step(1);
        bus.instr_ready = 1'b0;

        // Table: redirect-started single fetches, including the FF wrap
        foreach (vecs[i]) begin
            logic [7:0] a1;
            a1 = vecs[i].addr + 8'd1;
            rom[vecs[i].addr] = vecs[i].op;
            rom[a1] = vecs[i].imm_word;
            redirect(vecs[i].addr);
            wait_valid(20, lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_outputs", i),
                  {24'd0, bus.instr_word, bus.instr_imm, bus.instr_pc},
                  {24'd0, vecs[i].op, vecs[i].exp_imm, vecs[i].addr});
            check($sformatf("vec%0d_rd_en", i), {63'd0, bus.mem_rd_en}, 64'd0);
            exp_q.push_back(pack(vecs[i].op, vecs[i].exp_imm, vecs[i].addr));
            bus.instr_ready = 1'b1;
            step(1);
            bus.instr_ready = 1'b0;
            check($sformatf("vec%0d_next_pc", i), {56'd0, pc}, {56'd0, vecs[i].exp_next_pc});
        end

        // Test 5: ce once every 64 clks
        rom[8'h00] = 16'h0008;
        rom[8'h01] = 16'h0001;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_accept = 0;
        ce = 1'b0;
        bus.instr_ready = 1'b1;
        exp_q.push_back(pack(16'h0008, 8'h01, 8'h00));
        for (int t = 1; t <= 5; t++) begin
            snap = snapshot();
            stable = 1'b1;
            for (int k = 0; k < 63; k++) begin
                step(1);
                if (snapshot() !== snap) stable = 1'b0;
            end
            check($sformatf("t5_idle_stable_%0d", t), {63'd0, stable}, 64'd1);
            ce = 1'b1;
            step(1);
            ce = 1'b0;
            if (t == 3) check("t5_not_valid_t3", {63'd0, bus.instr_valid}, 64'd0);
            if (t == 4) check("t5_valid_t4", {63'd0, bus.instr_valid}, 64'd1);
        end
        bus.instr_ready = 1'b0;
        check("t5_pc_after", {56'd0, pc}, 64'h02);
`ifdef BORUSS_FETCH_STATS_EN
        check("t5_fetch_count", {48'd0, fetch_count}, n_accept);
`endif

        // Test 6: reset while in CAPT_IMM
        ce = 1'b1;
        redirect(8'h00);
        step(3);
        check("t6_in_capt_imm", {61'd0, state}, 64'd3);
        check("t6_word_before", {48'd0, bus.instr_word}, 64'h0008);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("t6_pc", {56'd0, pc}, 64'h00);
        check("t6_valid", {63'd0, bus.instr_valid}, 64'd0);
        check("t6_regs", {24'd0, bus.instr_word, bus.instr_imm, bus.instr_pc}, 64'd0);
        check("t6_state", {61'd0, state}, 64'd0);
`ifdef BORUSS_FETCH_STATS_EN
        check("t6_fetch_count", {48'd0, fetch_count}, 64'd0);
`endif

        check("scoreboard_drained", exp_q.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
